// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Holds the per-cycle action encoding and the command priority decoder.
package pc_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_JMP,
        ACT_CALL,
        ACT_RET
    } pc_act_e;

    // Resolve the decode commands into the single action taken this cycle.
    // Stall drops every command; otherwise ret > call > taken jump > increment.
    function automatic pc_act_e pc_decode(
        input logic en,
        input logic ret,
        input logic call,
        input logic jmp,
        input logic cond
    );
        pc_act_e act;
        if (!en)              act = ACT_HOLD;
        else if (ret)         act = ACT_RET;
        else if (call)        act = ACT_CALL;
        else if (jmp && cond) act = ACT_JMP;
        else                  act = ACT_INC;
        return act;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO, DEPTH entries of AW bits.
// Only the pointer is reset; entry contents are don't-care after reset.
// Push is ignored when full and pop is ignored when empty, so existing
// entries are never overwritten on overflow.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          R,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data,
    output logic          empty,
    output logic          full
);

    localparam int PW  = $clog2(DEPTH + 1);
    localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  mem [DEPTH];
    logic [PW-1:0]  sp;
    logic [AIW-1:0] wr_idx;
    logic [AIW-1:0] rd_idx;

    // Pointer counts 0..DEPTH; write slot is sp, top-of-stack is sp-1.
    always_comb begin
        wr_idx = AIW'(sp);
        rd_idx = AIW'(sp - PW'(1));
        empty  = (sp == '0);
        full   = (sp == PW'(DEPTH));
    end

    assign top_data = mem[rd_idx];

    // Stack pointer: push and pop are mutually exclusive from the caller.
    always_ff @(posedge clk) begin
        if (R)
            sp <= '0;
        else if (push && !full)
            sp <= sp + PW'(1);
        else if (pop && !empty)
            sp <= sp - PW'(1);
    end

    // Entry storage has no reset; only live entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (!R && push && !full)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Parametrised program counter with stall, conditional jump and an
// optional call/return stack.
// Build option: PC_CALL_STACK_EN enables the return stack, its flags and
// the sticky overflow/underflow err. Without it call is a plain jump, ret
// is an increment, flags read empty and err reads 0.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int            AW        = 8,
    parameter int            DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          R,
    input  logic          en,
    input  logic          jmp,
    input  logic          cond,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc,
    output logic          stack_empty,
    output logic          stack_full,
    output logic          err
);

    pc_act_e       act;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_nxt;

    assign act    = pc_decode(en, ret, call, jmp, cond);
    assign pc_inc = pc + AW'(1);

`ifdef PC_CALL_STACK_EN
    logic [AW-1:0] stk_top;
    logic          stk_push;
    logic          stk_pop;
    logic          err_set;

    assign stk_push = (act == ACT_CALL);
    assign stk_pop  = (act == ACT_RET);

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .R         (R),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    // Next-pc mux; an empty-stack return falls through to increment.
    always_comb begin
        pc_nxt = pc;
        case (act)
            ACT_INC:  pc_nxt = pc_inc;
            ACT_JMP:  pc_nxt = target;
            ACT_CALL: pc_nxt = target;
            ACT_RET:  pc_nxt = stack_empty ? pc_inc : stk_top;
            default:  pc_nxt = pc;
        endcase
    end

    assign err_set = (stk_push && stack_full) || (stk_pop && stack_empty);

    // Sticky error: set on overflow/underflow, cleared only by reset.
    always_ff @(posedge clk) begin
        if (R)
            err <= 1'b0;
        else if (err_set)
            err <= 1'b1;
    end
`else
    // Next-pc mux without a stack: call jumps, ret just increments.
    always_comb begin
        pc_nxt = pc;
        case (act)
            ACT_INC:  pc_nxt = pc_inc;
            ACT_JMP:  pc_nxt = target;
            ACT_CALL: pc_nxt = target;
            ACT_RET:  pc_nxt = pc_inc;
            default:  pc_nxt = pc;
        endcase
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign err         = 1'b0;
`endif

    // Program counter register.
    always_ff @(posedge clk) begin
        if (R)
            pc <= RESET_VEC;
        else
            pc <= pc_nxt;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (AW=8, DEPTH=4, RESET_VEC=F0).
// A queue-based reference model tracks pc, the return stack and err.
module tb_pc_sequencer;

    localparam int         AW    = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'hF0;

    logic          clk = 1'b0;
    logic          R = 1'b1, en = 1'b0, jmp = 1'b0, cond = 1'b0, call = 1'b0, ret = 1'b0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] pc;
    logic          stack_empty, stack_full, err;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_err;

    typedef struct {
        logic       r, e, j, c, cl, rt;
        logic [7:0] tgt;
        logic [7:0] exp_pc;
        logic       exp_empty, exp_full, exp_err;
    } vec_t;

    vec_t vecs[8];

    pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_VEC(RV)) dut (
        .clk(clk), .R(R), .en(en), .jmp(jmp), .cond(cond), .call(call),
        .ret(ret), .target(target), .pc(pc), .stack_empty(stack_empty),
        .stack_full(stack_full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of one clock edge.
    task automatic model_step(input logic r, e, j, c, cl, rt, input logic [7:0] tgt);
        if (r) begin
            m_pc = RV;
            m_stk.delete();
            m_err = 1'b0;
        end else if (e) begin
            if (rt) begin
`ifdef PC_CALL_STACK_EN
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = m_pc + 8'd1; m_err = 1'b1; end
`else
                m_pc = m_pc + 8'd1;
`endif
            end else if (cl) begin
`ifdef PC_CALL_STACK_EN
                if (m_stk.size() < DEPTH) m_stk.push_back(8'(m_pc + 8'd1));
                else m_err = 1'b1;
`endif
                m_pc = tgt;
            end else if (j && c) begin
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    // Drive one cycle, advance the model and compare every output to it.
    task automatic cmd(input string name, input logic r, e, j, c, cl, rt, input logic [7:0] tgt);
        R = r; en = e; jmp = j; cond = c; call = cl; ret = rt; target = tgt;
        @(posedge clk);
        #1;
        model_step(r, e, j, c, cl, rt, tgt);
        check({name, ".pc"},    32'(pc),          32'(m_pc));
        check({name, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
        check({name, ".full"},  32'(stack_full),  32'(m_stk.size() == DEPTH));
        check({name, ".err"},   32'(err),         32'(m_err));
    endtask

    initial begin
        int wraps;
        logic [7:0] prev;

        // ---- table-driven: reset, conditional jump, stall ----
        //           r  e  j  c  cl rt tgt    pc     emp ful err
        vecs[0] = '{1, 0, 0, 0, 0, 0, 8'h00, 8'hF0, 1, 0, 0};
        vecs[1] = '{0, 1, 1, 1, 0, 0, 8'd10, 8'd10, 1, 0, 0};
        vecs[2] = '{0, 1, 1, 0, 0, 0, 8'd40, 8'd11, 1, 0, 0};
        vecs[3] = '{0, 1, 1, 1, 0, 0, 8'd40, 8'd40, 1, 0, 0};
        vecs[4] = '{0, 0, 1, 1, 0, 0, 8'd77, 8'd40, 1, 0, 0};
        vecs[5] = '{0, 0, 0, 0, 1, 0, 8'd55, 8'd40, 1, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 1, 8'd55, 8'd40, 1, 0, 0};
        vecs[7] = '{0, 1, 0, 1, 0, 0, 8'd99, 8'd41, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            cmd($sformatf("vec%0d", i), vecs[i].r, vecs[i].e, vecs[i].j, vecs[i].c,
                vecs[i].cl, vecs[i].rt, vecs[i].tgt);
            check($sformatf("vec%0d.tpc", i),  32'(pc),          32'(vecs[i].exp_pc));
            check($sformatf("vec%0d.temp", i), 32'(stack_empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d.tful", i), 32'(stack_full),  32'(vecs[i].exp_full));
            check($sformatf("vec%0d.terr", i), 32'(err),         32'(vecs[i].exp_err));
        end

        // ---- increment and wrap: 260 enabled cycles from F0 ----
        cmd("wrap_rst", 1, 0, 0, 0, 0, 0, 8'h00);
        wraps = 0;
        prev  = pc;
        for (int i = 0; i < 260; i++) begin
            cmd("wrap", 0, 1, 0, 0, 0, 0, 8'h00);
            if (prev == 8'hFF && pc == 8'h00) wraps++;
            prev = pc;
        end
        check("wrap_count", 32'(wraps), 32'd1);
        check("wrap_final", 32'(pc), 32'(8'hF0 + 8'd4));

        // ---- nested call / ret ----
        cmd("nest_rst", 1, 0, 0, 0, 0, 0, 8'h00);
        cmd("nest_j20", 0, 1, 1, 1, 0, 0, 8'd20);
        cmd("nest_c80", 0, 1, 0, 0, 1, 0, 8'd80);
        check("nest_c80_k", 32'(pc), 32'd80);
        cmd("nest_c90", 0, 1, 0, 0, 1, 0, 8'd90);
        check("nest_c90_k", 32'(pc), 32'd90);
        cmd("nest_r1", 0, 1, 0, 0, 0, 1, 8'd0);
        cmd("nest_r2", 0, 1, 0, 0, 0, 1, 8'd0);
`ifdef PC_CALL_STACK_EN
        check("nest_pc", 32'(pc), 32'd21);
        check("nest_empty", 32'(stack_empty), 32'd1);
        check("nest_err", 32'(err), 32'd0);

        // ---- overflow / underflow, DEPTH=4 ----
        cmd("ovf_rst", 1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            cmd($sformatf("ovf_call%0d", i), 0, 1, 0, 0, 1, 0, 8'(i));
            if (i == 4) check("ovf_full4", 32'(stack_full), 32'd1);
        end
        check("ovf_pc5", 32'(pc), 32'd5);
        check("ovf_err", 32'(err), 32'd1);
        for (int i = 1; i <= 5; i++)
            cmd($sformatf("ovf_ret%0d", i), 0, 1, 0, 0, 0, 1, 8'h00);
        check("unf_pc", 32'(pc), 32'hF2);
        check("unf_err", 32'(err), 32'd1);

        // ---- call+ret same cycle, then mid-stack reset ----
        cmd("cr_call", 0, 1, 0, 0, 1, 0, 8'd30);
        cmd("cr_both", 0, 1, 0, 0, 1, 1, 8'd60);
        check("cr_pc", 32'(pc), 32'hF3);
        check("cr_empty", 32'(stack_empty), 32'd1);
        cmd("cr_call2", 0, 1, 0, 0, 1, 0, 8'd30);
        cmd("cr_rst", 1, 1, 0, 0, 1, 0, 8'd70);
        check("cr_rst_pc", 32'(pc), 32'hF0);
        check("cr_rst_empty", 32'(stack_empty), 32'd1);
        check("cr_rst_err", 32'(err), 32'd0);
`else
        check("nest_pc", 32'(pc), 32'd92);
        cmd("ns_c50", 0, 1, 0, 0, 1, 0, 8'd50);
        check("ns_c50_k", 32'(pc), 32'd50);
        cmd("ns_ret", 0, 1, 0, 0, 0, 1, 8'd0);
        check("ns_ret_k", 32'(pc), 32'd51);
        check("ns_empty", 32'(stack_empty), 32'd1);
        check("ns_full", 32'(stack_full), 32'd0);
        check("ns_err", 32'(err), 32'd0);
`endif

        // ---- randomized against the model ----
        for (int i = 0; i < 400; i++) begin
            cmd("rand",
                ($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 80),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 25),
                8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter that generalises the team's 2-bit jump counter into an AW-bit sequencer with stall, conditional jump, and an optional call/return-address stack. It sits between the instruction-decode logic (commands and target) and the instruction memory address port (`pc`). It advances by one per enabled cycle unless redirected. All state updates on the rising edge of `clk`.

## Interface
- `AW`, default 8: program-counter width in bits (≥2).
- `DEPTH`, default 4: return-stack entries (≥1); used only with the stack compiled in.
- `RESET_VEC`, default 0: value loaded into `pc` on reset (AW bits).
- `clk`  in  1: single clock, rising-edge.
- `R`  in  1: reset, synchronous, active-high.
- `en`  in  1: advance enable; 0 = stall, all commands ignored.
- `jmp`  in  1: conditional jump request.
- `cond`  in  1: jump condition; a jump is taken only when `jmp & cond`.
- `call`  in  1: subroutine call to `target`, pushing the return address.
- `ret`  in  1: return to the address on top of stack.
- `target`  in  AW: jump/call destination.
- `pc`  out  AW: current program counter (registered).
- `stack_empty`  out  1: stack holds 0 entries.
- `stack_full`  out  1: stack holds DEPTH entries.
- `err`  out  1: sticky; stack overflow or underflow occurred.

## Operation
- Reset (`R`=1) overrides everything: `pc`=RESET_VEC, stack pointer=0, `stack_empty`=1, `stack_full`=0, `err`=0.
- `en`=0: `pc`, stack, and `err` hold; `jmp`, `call`, `ret` are dropped (not queued).
- With `en`=1, exactly one action per cycle, priority `ret` > `call` > `jmp` > increment.
- Increment: `pc` ← `pc`+1 mod 2^AW; all-ones wraps to 0.
- Jump: `jmp & cond` → `pc` ← `target`. `jmp & !cond` → plain increment.
- Call, stack not full: push (`pc`+1 mod 2^AW); `pc` ← `target`.
- Call, stack full: `pc` ← `target`; no push, no overwrite of existing entries; `err` ← 1.
- Ret, stack not empty: `pc` ← top entry; pop.
- Ret, stack empty: `pc` ← `pc`+1; `err` ← 1.
- `call` and `ret` together: `ret` wins; `call` is discarded.
- `err` clears only on reset.
- Stack pointer is ceil(log2(DEPTH+1)) bits and counts 0..DEPTH. The flags are decoded from it combinationally off registered state.

## Timing
- One-cycle latency: a command sampled at edge N sets `pc` after edge N. No bubbles.
- `pc`, `err`, and the flags are registered or derived only from registers. There is no combinational path from inputs to outputs.
- Back-to-back `call`/`ret` on consecutive cycles is supported. A `ret` returns the address pushed by the immediately preceding `call` (the push is visible the next cycle).
- Reset asserted mid-sequence takes effect at the next edge. Stack contents become don't-care; only the pointer resets.

## Configuration
- `PC_CALL_STACK_EN` defined: the return stack, `stack_empty`, `stack_full`, and overflow/underflow `err` are implemented as above.
- Not defined:
  - `call` behaves as an unconditional jump to `target`.
  - `ret` behaves as increment.
  - `stack_empty`=1 and `stack_full`=0 constantly.
  - `err`=0 constantly.
  - No storage is inferred.

## Structure
- Shared package `pc_pkg`: action enum (ACT_HOLD, ACT_INC, ACT_JMP, ACT_CALL, ACT_RET) and the priority-decode function from (`en`, `ret`, `call`, `jmp`, `cond`).
- Sub-module `pc_ret_stack`: LIFO of DEPTH×AW with push/pop, synchronous reset of the pointer, and full/empty flags. It is instantiated only under `PC_CALL_STACK_EN`.
- The top level holds the `pc` register, the next-pc mux, and the sticky `err`.

## Test plan
- Reset then `en`=1 for 260 cycles, AW=8, RESET_VEC=8'hF0 → `pc` steps F0..FF, 00, ...; wraps exactly once per 256 cycles.
- `pc`=10, `jmp`=1 with `cond`=0 then `cond`=1, `target`=40 → `pc` = 11, then 40. Same with `en`=0 → `pc` holds 10.
- `call` to 80 at `pc`=20, then `call` to 90 at `pc`=80, then `ret`, `ret` → `pc` = 80, 90, 81, 21; `stack_empty`=1 at the end, `err`=0.
- DEPTH=4: five calls → `stack_full`=1 after the fourth call. The fifth call jumps to `target`, sets `err`=1, and the stack is unchanged. Five rets → fifth ret increments `pc`, `err` stays 1.
- `call`+`ret` in the same cycle with one entry on the stack → pops to the entry, nothing pushed. Then `R`=1 mid-stack → `pc`=RESET_VEC, `stack_empty`=1, `err`=0.
- Build without `PC_CALL_STACK_EN`: `call` to 50 → `pc`=50; `ret` → `pc`=51; flags stay empty=1, full=0, `err`=0.
